branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Control-transfer sequencer for the LC-3b pipeline; sits at the branch-resolution stage beside the condition-code logic.
- Decides taken/not-taken for BR, JSR/JSRR, JMP/RET and TRAP, and pulses a flush of younger stages.
- Writes the R7 link, fetches the TRAP vector through a data-memory handshake, then drives a redirect handshake to fetch.
- Holds the resolution stage while a transfer is outstanding and keeps a saturating taken-transfer counter.

Parameters:
- CNT_W, 16, width of taken-transfer counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- res_valid  in  1  resolution-stage instruction valid.
- res_ir  in  16  instruction word (lc3b_word).
- res_pc  in  16  incremented PC of that instruction (PC+2).
- cc_nzp  in  3  current condition codes (lc3b_nzp) {n,z,p}.
- br_target  in  16  PC-relative target from datapath adder.
- base_r  in  16  BaseR register value (JMP/JSRR).
- flush  out  1  kill younger stages.
- hold  out  1  stall resolution stage and upstream.
- link_we  out  1  write link_data to R7.
- link_data  out  16  link value.
- dmem_read  out  1  trap-vector read request.
- dmem_addr  out  16  trap-vector address.
- dmem_resp  in  1  read complete.
- dmem_rdata  in  16  read data.
- redirect_valid  out  1  new PC available.
- redirect_pc  out  16  new PC.
- redirect_ready  in  1  fetch accepts redirect.
- cnt_clr  in  1  synchronous clear of taken counter.
- taken_cnt  out  CNT_W  taken-transfer count.

Behaviour:
- Reset (async, reset_n=0): state IDLE; tgt_q and taken_cnt 0. All outputs 0; redirect_pc=0, dmem_addr=0. A pending redirect or trap read is dropped.
- States: IDLE, TRAP_RD, REDIRECT. hold = (state != IDLE), registered-state decode.
- Decode acts in IDLE only, when res_valid=1. Opcode is res_ir[15:12]. All inputs are sampled that cycle, cycle N.
- BR (0000): taken iff (ir[11]&n)|(ir[10]&z)|(ir[9]&p). nzp field 000 is never taken. Target = br_target.
- JSR (0100): always taken. Target = br_target if ir[11]=1, else base_r (JSRR).
- JMP (1100): always taken. Target = base_r.
- TRAP (1111): always taken. Target comes from memory.
- Any taken transfer in cycle N:
  - flush=1 in cycle N only (combinational).
  - Taken counter increments at end of N.
  - Non-TRAP: tgt_q<=target; state->REDIRECT.
- Link write (JSR/JSRR/TRAP): link_we=1 in cycle N with link_data=res_pc. base_r is sampled in the same cycle, so JSRR R7 uses the old R7.
- TRAP: state->TRAP_RD.
  - dmem_read=1 and dmem_addr={7'b0, ir[7:0], 1'b0} from N+1, held stable until dmem_resp.
  - On dmem_resp: tgt_q<=dmem_rdata; ->REDIRECT next cycle.
  - dmem_resp in the same cycle as the first request is legal.
- REDIRECT: redirect_valid=1, redirect_pc=tgt_q, both held stable until redirect_ready=1 -> IDLE. Minimum redirect latency is N+1; accepted in N+1 returns IDLE at N+2.
- Not-taken BR, any other opcode, or res_valid=0: no outputs asserted, state stays IDLE.
- res_valid while state != IDLE: ignored, because upstream is held.
- redirect_ready outside REDIRECT: ignored. dmem_resp outside TRAP_RD: ignored.
- Counter:
  - Saturates at all-ones with no wrap.
  - cnt_clr wins over a same-cycle increment (result 0).
  - Increment happens at decode, so a transfer killed by reset mid-operation has already been counted.

Decomposition:
- lc3b_types gains:
  - lc3b_opcode enum: op_br=0000, op_jsr=0100, op_jmp=1100, op_trap=1111.
  - branch_ctrl_state_t enum: IDLE, TRAP_RD, REDIRECT.
- Existing lc3b_word and lc3b_nzp are reused.
- One combinational sub-module, br_cond_eval: inputs ir[11:9] and cc_nzp; output taken. Also used by the datapath.

Test Plan:
- BRz (ir=0x0404), cc=010, br_target=0x3010: flush at N; redirect_valid N+1 with pc 0x3010; ready at N+3 -> IDLE at N+4; taken_cnt=1.
- BRn, cc=001: no flush, no redirect, hold=0; BR with nzp=000 and cc=111: not taken.
- JSRR R7 (ir=0x41C0), base_r=0x4000, res_pc=0x3002: link_we at N with 0x3002; redirect_pc=0x4000.
- TRAP x25 (ir=0xF025): dmem_addr=0x004A from N+1; dmem_resp 3 cycles later with 0x0520 -> redirect_pc=0x0520; hold=1 throughout.
- reset_n=0 during REDIRECT and during TRAP_RD: all outputs 0 immediately; after release, a new BR resolves normally.
- Counter: CNT_W=4, 16 taken transfers -> 0xF held; cnt_clr together with a taken BR -> 0.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word, condition-code, opcode and branch-control state types
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [2:0] lc3b_nzp;
  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_jsr  = 4'b0100,
    op_jmp  = 4'b1100,
    op_trap = 4'b1111
  } lc3b_opcode;
  typedef enum logic [1:0] {
    IDLE,
    TRAP_RD,
    REDIRECT
  } branch_ctrl_state_t;
endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: BR taken test of the instruction nzp mask against the condition codes
module br_cond_eval
  import lc3b_types::*;
(
  input  lc3b_nzp ir_nzp,
  input  lc3b_nzp cc_nzp,
  output logic    taken
);
  assign taken = |(ir_nzp & cc_nzp);
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: control-transfer sequencer with flush, R7 link, trap-vector fetch and redirect handshake
module branch_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             res_valid,
  input  lc3b_word         res_ir,
  input  lc3b_word         res_pc,
  input  lc3b_nzp          cc_nzp,
  input  lc3b_word         br_target,
  input  lc3b_word         base_r,
  output logic             flush,
  output logic             hold,
  output logic             link_we,
  output lc3b_word         link_data,
  output logic             dmem_read,
  output lc3b_word         dmem_addr,
  input  logic             dmem_resp,
  input  lc3b_word         dmem_rdata,
  output logic             redirect_valid,
  output lc3b_word         redirect_pc,
  input  logic             redirect_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] taken_cnt
);
  branch_ctrl_state_t state;
  lc3b_word tgt_q;
  logic [7:0] vec_q;
  logic cond_tk, dec, is_br, is_jsr, is_jmp, is_trap, taken;
  lc3b_word target;
  logic ir_unused;
  assign ir_unused = res_ir[8];
  br_cond_eval u_cond (
    .ir_nzp(res_ir[11:9]),
    .cc_nzp(cc_nzp),
    .taken (cond_tk)
  );
  // decode only while idle; reset gating keeps every output low during reset
  always_comb begin
    dec     = reset_n && state == IDLE && res_valid;
    is_br   = res_ir[15:12] == op_br;
    is_jsr  = res_ir[15:12] == op_jsr;
    is_jmp  = res_ir[15:12] == op_jmp;
    is_trap = res_ir[15:12] == op_trap;
    taken   = dec && ((is_br && cond_tk) || is_jsr || is_jmp || is_trap);
    target  = (is_br || (is_jsr && res_ir[11])) ? br_target : base_r;
  end
  assign flush          = taken;
  assign hold           = state != IDLE;
  assign link_we        = dec && (is_jsr || is_trap);
  assign link_data      = link_we ? res_pc : '0;
  assign dmem_read      = state == TRAP_RD;
  assign dmem_addr      = dmem_read ? {7'b0, vec_q, 1'b0} : '0;
  assign redirect_valid = state == REDIRECT;
  assign redirect_pc    = redirect_valid ? tgt_q : '0;
  // transfer sequencing: idle -> (trap read) -> redirect -> idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tgt_q <= '0;
      vec_q <= '0;
    end else if (state == IDLE && taken) begin
      state <= is_trap ? TRAP_RD : REDIRECT;
      tgt_q <= is_trap ? tgt_q : target;
      vec_q <= res_ir[7:0];
    end else if (state == TRAP_RD && dmem_resp) begin
      state <= REDIRECT;
      tgt_q <= dmem_rdata;
    end else if (state == REDIRECT && redirect_ready) begin
      state <= IDLE;
    end
  end
  // saturating taken counter; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) taken_cnt <= '0;
    else taken_cnt <= cnt_clr ? '0 : (taken && !(&taken_cnt)) ? taken_cnt + CNT_W'(1) : taken_cnt;
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: randomized and directed checking of branch_ctrl against a behavioural model
module tb_branch_ctrl;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;
  logic clk = 0, reset_n = 0;
  logic res_valid = 0, dmem_resp = 0, redirect_ready = 0, cnt_clr = 0;
  logic [15:0] res_ir = 0, res_pc = 0, br_target = 0, base_r = 0, dmem_rdata = 0;
  logic [2:0] cc_nzp = 0;
  logic flush, hold, link_we, dmem_read, redirect_valid;
  logic [15:0] link_data, dmem_addr, redirect_pc;
  logic [CNT_W-1:0] taken_cnt;
  int vectors = 0, fails = 0;
  bit run = 0;
  bit m_trap, m_redir;
  logic [15:0] m_tgt;
  logic [7:0] m_vec;
  int m_cnt;

  branch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .res_valid(res_valid), .res_ir(res_ir), .res_pc(res_pc),
    .cc_nzp(cc_nzp), .br_target(br_target), .base_r(base_r), .flush(flush), .hold(hold),
    .link_we(link_we), .link_data(link_data), .dmem_read(dmem_read), .dmem_addr(dmem_addr),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .cnt_clr(cnt_clr),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    vectors++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit m_dec();
    return reset_n && !m_trap && !m_redir && res_valid;
  endfunction

  function automatic bit m_taken();
    logic [3:0] op;
    bit br;
    op = res_ir[15:12];
    br = (res_ir[11] && cc_nzp[2]) || (res_ir[10] && cc_nzp[1]) || (res_ir[9] && cc_nzp[0]);
    return m_dec() && ((op == 4'h0 && br) || op == 4'h4 || op == 4'hC || op == 4'hF);
  endfunction

  function automatic bit m_link();
    return m_dec() && (res_ir[15:12] == 4'h4 || res_ir[15:12] == 4'hF);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_trap = 0; m_redir = 0; m_tgt = 0; m_vec = 0; m_cnt = 0;
    end else begin
      bit t;
      t = m_taken();
      if (!m_trap && !m_redir) begin
        if (t && res_ir[15:12] == 4'hF) begin
          m_trap = 1;
          m_vec = res_ir[7:0];
        end else if (t) begin
          m_redir = 1;
          m_tgt = (res_ir[15:12] == 4'h0 || (res_ir[15:12] == 4'h4 && res_ir[11])) ? br_target : base_r;
        end
      end else if (m_trap) begin
        if (dmem_resp) begin
          m_trap = 0; m_redir = 1; m_tgt = dmem_rdata;
        end
      end else if (redirect_ready) m_redir = 0;
      m_cnt = cnt_clr ? 0 : (t && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("flush", 16'(flush), 16'(m_taken()));
      chk("hold", 16'(hold), 16'(m_trap || m_redir));
      chk("link_we", 16'(link_we), 16'(m_link()));
      chk("link_data", link_data, m_link() ? res_pc : 16'h0);
      chk("dmem_read", 16'(dmem_read), 16'(m_trap));
      chk("dmem_addr", dmem_addr, m_trap ? 16'(m_vec) * 16'd2 : 16'h0);
      chk("redirect_valid", 16'(redirect_valid), 16'(m_redir));
      chk("redirect_pc", redirect_pc, m_redir ? m_tgt : 16'h0);
      chk("taken_cnt", 16'(taken_cnt), 16'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    run = 1;
    #2;
    chk("rst_hold", 16'(hold), 16'h0);
    chk("rst_rv", 16'(redirect_valid), 16'h0);
    chk("rst_cnt", 16'(taken_cnt), 16'h0);
    tick(); tick();
    reset_n = 1;
    tick();
    res_valid = 1; res_ir = 16'h0404; cc_nzp = 3'b010; br_target = 16'h3010;
    #3; chk("brz_flush", 16'(flush), 16'h1); chk("brz_hold0", 16'(hold), 16'h0);
    tick(); res_valid = 0;
    #3; chk("brz_rv", 16'(redirect_valid), 16'h1); chk("brz_pc", redirect_pc, 16'h3010); chk("brz_hold", 16'(hold), 16'h1);
    tick(); tick();
    redirect_ready = 1;
    tick(); redirect_ready = 0;
    #3; chk("brz_idle", 16'(hold), 16'h0); chk("brz_cnt", 16'(taken_cnt), 16'h1);
    tick();
    res_valid = 1; res_ir = 16'h0800; cc_nzp = 3'b001;
    #3; chk("brn_flush", 16'(flush), 16'h0);
    tick(); res_ir = 16'h0000; cc_nzp = 3'b111;
    #3; chk("brn_hold", 16'(hold), 16'h0); chk("br000_flush", 16'(flush), 16'h0);
    tick();
    res_ir = 16'h41C0; base_r = 16'h4000; res_pc = 16'h3002; br_target = 16'h1111;
    #3; chk("jsrr_we", 16'(link_we), 16'h1); chk("jsrr_link", link_data, 16'h3002);
    tick(); res_valid = 0;
    #3; chk("jsrr_pc", redirect_pc, 16'h4000);
    redirect_ready = 1; tick(); redirect_ready = 0;
    res_valid = 1; res_ir = 16'hF025; res_pc = 16'h3004;
    #3; chk("trap_link", link_data, 16'h3004); chk("trap_flush", 16'(flush), 16'h1);
    tick(); res_valid = 0;
    #3; chk("trap_rd", 16'(dmem_read), 16'h1); chk("trap_addr", dmem_addr, 16'h004A);
    tick(); tick();
    #3; chk("trap_addr_hold", dmem_addr, 16'h004A); chk("trap_hold", 16'(hold), 16'h1);
    tick(); dmem_resp = 1; dmem_rdata = 16'h0520;
    tick(); dmem_resp = 0;
    #3; chk("trap_pc", redirect_pc, 16'h0520); chk("trap_rd_done", 16'(dmem_read), 16'h0); chk("trap_hold2", 16'(hold), 16'h1);
    redirect_ready = 1; tick(); redirect_ready = 0;
    res_valid = 1; res_ir = 16'h0E00; br_target = 16'h1234;
    tick(); res_valid = 0;
    #1; chk("rr_pre", 16'(redirect_valid), 16'h1);
    reset_n = 0;
    #1; chk("rr_rv", 16'(redirect_valid), 16'h0); chk("rr_pc", redirect_pc, 16'h0); chk("rr_hold", 16'(hold), 16'h0);
    tick(); reset_n = 1; tick();
    res_valid = 1; res_ir = 16'h0404; cc_nzp = 3'b010; br_target = 16'h2222;
    tick(); res_valid = 0;
    #3; chk("rr_after", redirect_pc, 16'h2222);
    redirect_ready = 1; tick(); redirect_ready = 0;
    res_valid = 1; res_ir = 16'hF030;
    tick(); res_valid = 0;
    #1; chk("rt_pre", 16'(dmem_read), 16'h1);
    reset_n = 0;
    #1; chk("rt_rd", 16'(dmem_read), 16'h0); chk("rt_addr", dmem_addr, 16'h0); chk("rt_hold", 16'(hold), 16'h0);
    tick(); reset_n = 1; tick();
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] r;
      logic [3:0] op;
      r = $urandom;
      case ($urandom_range(0, 4))
        0: op = 4'h0;
        1: op = 4'h4;
        2: op = 4'hC;
        3: op = 4'hF;
        default: op = r[31:28];
      endcase
      res_ir = {op, r[11:0]};
      res_valid = $urandom_range(0, 9) < 7;
      cc_nzp = 3'($urandom);
      res_pc = 16'($urandom); br_target = 16'($urandom); base_r = 16'($urandom);
      dmem_rdata = 16'($urandom);
      dmem_resp = $urandom_range(0, 9) < 3;
      redirect_ready = $urandom_range(0, 9) < 4;
      cnt_clr = $urandom_range(0, 39) == 0;
      reset_n = $urandom_range(0, 299) != 0;
      tick();
    end
    reset_n = 1; res_valid = 0; dmem_resp = 0; redirect_ready = 1; cnt_clr = 1;
    tick(); tick(); tick(); cnt_clr = 0;
    for (int i = 0; i < 16; i++) begin
      res_valid = 1; res_ir = 16'hC000; base_r = 16'(i);
      tick(); res_valid = 0;
      tick();
    end
    #3; chk("sat_cnt", 16'(taken_cnt), 16'h000F);
    tick();
    res_valid = 1; res_ir = 16'h0404; cc_nzp = 3'b010; cnt_clr = 1;
    #3; chk("clr_flush", 16'(flush), 16'h1);
    tick(); res_valid = 0; cnt_clr = 0;
    #3; chk("clr_cnt", 16'(taken_cnt), 16'h0);
    tick(); tick();
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
